// File: rtl/types_uart_rx_pkg.sv
// types_uart_rx_pkg: shared FSM state type, oversampling constants and majority helper for the UART receiver
package types_uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
    localparam int OVERSAMPLE   = 8;
    localparam int SAMPLE_EARLY = 3;
    localparam int SAMPLE_MID   = 4;
    localparam int SAMPLE_LATE  = 5;
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: sync byte FIFO; push/full in, pop/valid/head out, level = occupancy, head registered from the read pointer
module uart_rx_fifo #(
    parameter int LOG2_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic                pop,
    output logic                full,
    output logic                valid,
    output logic [7:0]          head,
    output logic [LOG2_DEPTH:0] level
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    logic [7:0] mem [DEPTH];
    logic [LOG2_DEPTH:0] wr_ptr, rd_ptr, rd_nxt;
    logic pop_do, push_do;
    assign level   = wr_ptr - rd_ptr;
    assign valid   = level != '0;
    assign full    = level[LOG2_DEPTH];
    assign pop_do  = pop & valid;
    assign push_do = push & (~full | pop_do);
    assign rd_nxt  = rd_ptr + {{LOG2_DEPTH{1'b0}}, pop_do};
    always_ff @(posedge clk)
        if (push_do) mem[wr_ptr[LOG2_DEPTH-1:0]] <= push_data;
    // a byte written into the slot that becomes the head must bypass the array
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{LOG2_DEPTH{1'b0}}, push_do};
            rd_ptr <= rd_nxt;
            head   <= (push_do && wr_ptr[LOG2_DEPTH-1:0] == rd_nxt[LOG2_DEPTH-1:0]) ? push_data : mem[rd_nxt[LOG2_DEPTH-1:0]];
        end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8x oversampling UART receiver (8N1) feeding a byte FIFO with saturating error counters
//   in : i_clk, i_nrst (async active-low), i_scaler (clocks per tick, 0 acts as 1), i_rx, i_rd_ready
//   out: o_rd_valid, o_rd_data, o_level, o_frame_err_cnt, o_ovf_cnt, o_busy
//   UART_RX_PARITY_EN adds a parity bit after the data and input i_parity_odd (1 = odd parity)
module uart_rx_capture
    import types_uart_rx_pkg::*;
#(
    parameter int LOG2_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [15:0]          i_scaler,
    input  logic                 i_rx,
    input  logic                 i_rd_ready,
`ifdef UART_RX_PARITY_EN
    input  logic                 i_parity_odd,
`endif
    output logic                 o_rd_valid,
    output logic [7:0]           o_rd_data,
    output logic [LOG2_DEPTH:0]  o_level,
    output logic [CNT_WIDTH-1:0] o_frame_err_cnt,
    output logic [CNT_WIDTH-1:0] o_ovf_cnt,
    output logic                 o_busy
);
    rx_state_t state_q, state_d;
    logic rx_meta, rx_sync, tick, bit_end, sample, maj, frame_ok, frame_bad, push, full, drop, par_err;
    logic [15:0] tick_cnt, tick_max;
    logic [3:0] tick_idx, tick_nxt;
    logic [2:0] samples, bit_idx;
    logic [7:0] shreg;
    assign tick_max  = (i_scaler == 16'd0) ? 16'd0 : i_scaler - 16'd1;
    // >= so that lowering the scaler mid-frame still wraps at the next tick
    assign tick      = tick_cnt >= tick_max;
    assign tick_nxt  = tick_idx + 4'd1;
    assign bit_end   = tick && tick_nxt == 4'(OVERSAMPLE);
    assign sample    = tick && (tick_nxt == 4'(SAMPLE_EARLY) || tick_nxt == 4'(SAMPLE_MID) || tick_nxt == 4'(SAMPLE_LATE));
    assign maj       = maj3(samples);
    assign frame_ok  = state_q == STOP && bit_end && maj && !par_err;
    assign frame_bad = state_q == STOP && bit_end && (!maj || par_err);
    assign drop      = push & full & ~(o_rd_valid & i_rd_ready);
    assign o_busy    = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rx_sync ? IDLE : START;
            START:   state_d = bit_end ? (maj ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
            DATA:    state_d = (bit_end && bit_idx == 3'd7) ? PARITY : DATA;
`else
            DATA:    state_d = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
`endif
            PARITY:  state_d = bit_end ? STOP : PARITY;
            STOP:    state_d = bit_end ? (maj ? IDLE : BREAK) : STOP;
            BREAK:   state_d = rx_sync ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            state_q  <= IDLE;
            tick_cnt <= '0;
            tick_idx <= '0;
            samples  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            push     <= 1'b0;
        end else begin
            rx_meta  <= i_rx;
            rx_sync  <= rx_meta;
            state_q  <= state_d;
            // holding the counters in IDLE aligns sampling to the detected falling edge
            tick_cnt <= (state_q == IDLE || tick) ? 16'd0 : tick_cnt + 16'd1;
            tick_idx <= (state_q == IDLE || bit_end) ? 4'd0 : tick ? tick_nxt : tick_idx;
            push     <= frame_ok;
            if (sample) samples <= {samples[1:0], rx_sync};
            if (state_q == DATA && bit_end) begin
                shreg   <= {maj, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state_q == IDLE) par_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (state_q == PARITY && bit_end) par_err <= maj != (^shreg ^ i_parity_odd);
`endif
        end
    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) begin
            o_frame_err_cnt <= '0;
            o_ovf_cnt       <= '0;
        end else begin
            if (frame_bad && ~&o_frame_err_cnt) o_frame_err_cnt <= o_frame_err_cnt + CNT_WIDTH'(1);
            if (drop && ~&o_ovf_cnt) o_ovf_cnt <= o_ovf_cnt + CNT_WIDTH'(1);
        end
    uart_rx_fifo #(.LOG2_DEPTH(LOG2_DEPTH)) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_nrst),
        .push     (push),
        .push_data(shreg),
        .pop      (i_rd_ready),
        .full     (full),
        .valid    (o_rd_valid),
        .head     (o_rd_data),
        .level    (o_level)
    );
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed table-driven bench for uart_rx_capture
module tb_uart_rx_capture;
    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [15:0] i_scaler;
    logic        i_rx;
    logic        i_rd_ready;
`ifdef UART_RX_PARITY_EN
    logic        i_parity_odd = 1'b0;
`endif
    logic        o_rd_valid;
    logic [7:0]  o_rd_data;
    logic [4:0]  o_level;
    logic [15:0] o_frame_err_cnt;
    logic [15:0] o_ovf_cnt;
    logic        o_busy;
    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    uart_rx_capture #(.LOG2_DEPTH(4), .CNT_WIDTH(16)) dut (
        .i_clk          (i_clk),
        .i_nrst         (i_nrst),
        .i_scaler       (i_scaler),
        .i_rx           (i_rx),
        .i_rd_ready     (i_rd_ready),
`ifdef UART_RX_PARITY_EN
        .i_parity_odd   (i_parity_odd),
`endif
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_level        (o_level),
        .o_frame_err_cnt(o_frame_err_cnt),
        .o_ovf_cnt      (o_ovf_cnt),
        .o_busy         (o_busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          hold;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [15:0] exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        @(negedge i_clk);
        for (int b = 0; b < n; b++) begin
            i_rx = bits[b];
            repeat (8 * int'(i_scaler)) @(negedge i_clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_bits({stop, ^d ^ i_parity_odd, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop, d, 1'b0}, 10);
`endif
    endtask

    task automatic pop_one();
        @(negedge i_clk);
        i_rd_ready = 1'b1;
        @(negedge i_clk);
        i_rd_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, o_rd_valid, 0);
        chk({tag, "_data"}, o_rd_data, 0);
        chk({tag, "_level"}, o_level, 0);
        chk({tag, "_ferr"}, o_frame_err_cnt, 0);
        chk({tag, "_ovf"}, o_ovf_cnt, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 0,   1'b1, 8'h55, 16'd0};
        vecs[1] = '{8'hA3, 1'b1, 0,   1'b1, 8'hA3, 16'd0};
        vecs[2] = '{8'h00, 1'b1, 0,   1'b1, 8'h00, 16'd0};
        vecs[3] = '{8'hFF, 1'b1, 0,   1'b1, 8'hFF, 16'd0};
        vecs[4] = '{8'h3C, 1'b0, 100, 1'b0, 8'h00, 16'd1};
        vecs[5] = '{8'h7E, 1'b1, 0,   1'b1, 8'h7E, 16'd1};
        vecs[6] = '{8'h81, 1'b1, 0,   1'b1, 8'h81, 16'd1};
        i_nrst = 1'b0;
        i_rx = 1'b1;
        i_rd_ready = 1'b0;
        i_scaler = 16'd4;
        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_nrst = 1'b1;
        repeat (5) @(negedge i_clk);
        chk_zero("post_reset");

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (vecs[i].hold) @(negedge i_clk);
                chk($sformatf("v%0d_break_busy", i), o_busy, 1);
                i_rx = 1'b1;
            end
            repeat (8) @(negedge i_clk);
            chk($sformatf("v%0d_valid", i), o_rd_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk($sformatf("v%0d_data", i), o_rd_data, vecs[i].exp_data);
            chk($sformatf("v%0d_ferr", i), o_frame_err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_ovf", i), o_ovf_cnt, 0);
            chk($sformatf("v%0d_busy", i), o_busy, 0);
            if (o_rd_valid) pop_one();
            chk($sformatf("v%0d_empty", i), o_rd_valid, 0);
        end

        send_frame(8'h55, 1'b1);
        repeat (8) @(negedge i_clk);
        send_frame(8'hA3, 1'b1);
        repeat (8) @(negedge i_clk);
        chk("two_level", o_level, 2);
        chk("two_head0", o_rd_data, 8'h55);
        pop_one();
        chk("two_level1", o_level, 1);
        chk("two_head1", o_rd_data, 8'hA3);
        pop_one();
        chk("two_level0", o_level, 0);
        chk("two_valid0", o_rd_valid, 0);

        for (int i = 0; i < 18; i++) begin
            send_frame(8'(i), 1'b1);
            repeat (8) @(negedge i_clk);
        end
        chk("ovf_level", o_level, 16);
        chk("ovf_cnt", o_ovf_cnt, 2);
        chk("ovf_head", o_rd_data, 8'h00);
        chk("ovf_ferr", o_frame_err_cnt, 1);

        // pop exactly on the clock where the new byte is written into a full FIFO
        send_frame(8'h12, 1'b1);
        repeat (3) @(negedge i_clk);
        i_rd_ready = 1'b1;
        @(negedge i_clk);
        i_rd_ready = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("fullpop_level", o_level, 16);
        chk("fullpop_ovf", o_ovf_cnt, 2);
        chk("fullpop_head", o_rd_data, 8'h01);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), o_rd_valid, 1);
            chk($sformatf("drain%0d_data", i), o_rd_data, (i < 15) ? i + 1 : 8'h12);
            pop_one();
        end
        chk("drain_level", o_level, 0);

        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (100) @(negedge i_clk);
        chk("midrst_busy_before", o_busy, 1);
        i_nrst = 1'b0;
        #1;
        chk_zero("midrst");
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (8) @(negedge i_clk);
        send_frame(8'h5A, 1'b1);
        repeat (8) @(negedge i_clk);
        chk("clean_valid", o_rd_valid, 1);
        chk("clean_data", o_rd_data, 8'h5A);
        chk("clean_ferr", o_frame_err_cnt, 0);
        chk("clean_ovf", o_ovf_cnt, 0);
        pop_one();

        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("glitch_busy_set", o_busy, 1);
        repeat (4) @(negedge i_clk);
        i_rx = 1'b1;
        begin
            int n = 0;
            while (o_busy && n < 40) begin
                @(negedge i_clk);
                n++;
            end
        end
        chk("glitch_busy_clears", o_busy, 0);
        repeat (50) @(negedge i_clk);
        chk("glitch_valid", o_rd_valid, 0);
        chk("glitch_ferr", o_frame_err_cnt, 0);
        chk("glitch_ovf", o_ovf_cnt, 0);

        i_scaler = 16'd2;
        send_frame(8'hC5, 1'b1);
        repeat (8) @(negedge i_clk);
        chk("fast_valid", o_rd_valid, 1);
        chk("fast_data", o_rd_data, 8'hC5);
        pop_one();
        i_scaler = 16'd4;

`ifdef UART_RX_PARITY_EN
        i_parity_odd = 1'b0;
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge i_clk);
        chk("par_bad_ferr", o_frame_err_cnt, 1);
        chk("par_bad_valid", o_rd_valid, 0);
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge i_clk);
        chk("par_ok_valid", o_rd_valid, 1);
        chk("par_ok_data", o_rd_data, 8'h07);
        chk("par_ok_ferr", o_frame_err_cnt, 1);
        pop_one();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable UART receiver that consumes the SoC UART1 serial output (`o_uart1_td`) and turns it into a buffered byte stream.
- Used by on-board loopback/self-test logic and by the KC705 bench as an RTL counterpart to the behavioural receiver model.
- Oversamples the line 8x with a programmable scaler, assembles 8N1 frames and pushes bytes into a small FIFO.
- The FIFO drains through a valid/ready port and the block keeps saturating error counters.

Parameters:
- `LOG2_DEPTH`, 4, FIFO depth = 2**`LOG2_DEPTH` bytes.
- `CNT_WIDTH`, 16, width of the error counters.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_scaler`  in  16  clocks per oversample tick; 0 is treated as 1; bit period = 8*tick.
- `i_rx`  in  1  serial line; idle high; asynchronous to `i_clk`.
- `i_rd_ready`  in  1  consumer accepts the head byte.
- `o_rd_valid`  out  1  FIFO non-empty.
- `o_rd_data`  out  8  FIFO head byte.
- `o_level`  out  `LOG2_DEPTH`+1  current FIFO occupancy.
- `o_frame_err_cnt`  out  `CNT_WIDTH`  frames with bad stop bit (plus parity errors when enabled).
- `o_ovf_cnt`  out  `CNT_WIDTH`  bytes dropped because the FIFO was full.
- `o_busy`  out  1  FSM not in IDLE.

Behaviour:
- **Reset values:** all outputs 0, `o_rd_data` 0. Synchronizer flops reset to 1. FSM in IDLE. Tick counter 0.
- **Input sync:** `i_rx` passes through a 2-flop synchronizer; the FSM sees it 2 clocks late.
- **Tick generator:** counter counts to max(`i_scaler`,1)-1, then pulses `tick` and wraps. The counter is cleared on the IDLE->START transition so sampling is aligned to the falling edge.
  - A change of `i_scaler` mid-frame takes effect at the next wrap.
- **Sampling:** per bit, count 8 ticks. The bit value is the majority of the samples taken on ticks 3, 4 and 5.
- **FSM:**
  - IDLE: synced rx=0 -> START.
  - START: after 8 ticks, majority=1 (glitch) -> IDLE with no count; majority=0 -> DATA with bit index 0.
  - DATA: shift LSB-first; after bit 7 -> STOP (or PARITY when the feature is enabled).
  - STOP: after the 8th tick, majority=1 -> push the byte, -> IDLE.
    - Majority=0: increment `o_frame_err_cnt`, discard the byte, -> BREAK.
  - BREAK: wait until synced rx=1, then -> IDLE. Holding the line low never re-triggers.
- **Push timing:** the byte is written in the clock after the stop-bit decision; `o_rd_valid` rises the cycle after the write.
- **FIFO:** circular buffer with `LOG2_DEPTH`+1-bit pointers.
  - Pop occurs when `o_rd_valid` & `i_rd_ready`; `o_rd_data` is always the head, registered from the read pointer.
  - Push while full and no pop: byte dropped, `o_ovf_cnt`++.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: push only (`o_rd_valid` was 0).
  - `o_level` is updated on each clock to reflect that cycle's push/pop.
- **Counters:** saturate at all-ones; never wrap.
- **Mid-operation reset:** `i_nrst` low clears everything asynchronously. A frame in progress is lost; counters are not incremented for it.

Optional Feature:
- `UART_RX_PARITY_EN`: adds a PARITY state after bit 7 with even parity and a new input `i_parity_odd` (1 = odd).
  - Parity mismatch: `o_frame_err_cnt`++ and the byte is discarded. The FSM still checks the stop bit but counts only once per frame.
  - Without the macro: no PARITY state, no `i_parity_odd` port, 8N1 only.

Decomposition:
- Shared package `types_uart_rx_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Constant `OVERSAMPLE` = 8.
  - Constants for the sample ticks 3/4/5.
- One sub-module, `uart_rx_fifo`: parameterized sync FIFO exposing push, full, pop, valid, head data and level.
- Synchronizer, tick generator and FSM stay in `uart_rx_capture`.

Test Plan:
- `i_scaler`=4 (bit = 32 clocks); send 0x55 then 0xA3 as 8N1 -> `o_rd_valid`, `o_rd_data`=0x55 then 0xA3; `o_level` peaks at 2; counters stay 0.
- `i_rd_ready`=0; send 18 bytes 0x00..0x11 with `LOG2_DEPTH`=4 -> `o_level`=16, `o_ovf_cnt`=2; draining yields 0x00..0x0F in order.
- Send 0x3C with stop bit forced 0, then hold the line low for 100 clocks, release, send 0x7E -> `o_frame_err_cnt`=1; only 0x7E appears.
- Pulse rx low for 8 clocks (under half a bit) with `i_scaler`=4 -> no byte pushed, `o_busy` returns to 0 within 40 clocks, counters 0.
- FIFO full with `i_rd_ready`=1 on the cycle a new byte is pushed -> `o_level` stays 16, `o_ovf_cnt` unchanged; assert `i_nrst`=0 mid-frame -> all outputs 0 immediately; the next clean frame is received correctly.
- With `UART_RX_PARITY_EN` and `i_parity_odd`=0: send 0x07 with parity bit 0 -> `o_frame_err_cnt`=1, no byte; send 0x07 with parity 1 -> byte 0x07 is delivered.
